// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: control/status pin positions,
// arbiter state encodings and a helper that builds the request pin word.
package ram_arbiter_pkg;

   // Bit positions inside ram_ctrl_to_hw / ram_ctrl_from_hw
   localparam int unsigned RAM_READ_PIN  = 0;
   localparam int unsigned RAM_WRITE_PIN = 1;
   localparam int unsigned RAM_ACK       = 0;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT_ACK,
      ARB_RELEASE
   } arb_state_t;

   // One-hot request pin word: write pin for we=1, read pin otherwise
   function automatic logic [31:0] ctrl_pin(input logic we);
      logic [31:0] v;
      v = '0;
      if (we) v[RAM_WRITE_PIN] = 1'b1;
      else    v[RAM_READ_PIN]  = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// rr_pick2: two-input grant selection. With both requesting, the port not
// served last wins (round-robin) or port 1 wins when fixed is set.
module rr_pick2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   input  logic fixed,
   output logic grant
);

   // Grant index; only meaningful while req0 | req1
   always_comb begin
      grant = 1'b0;
      if (req0 && req1) grant = fixed ? 1'b1 : ~last;
      else              grant = req1;
   end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the RAM four-phase handshake between port 0 (CPU/mobo
// sequencer) and port 1 (VGA fetch); every output is registered.
// Optional watchdog: define RAM_ARB_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYC busy cycles and raise the sticky err flag.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int FIXED_PRIO  = 0,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              done0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done1,
   output logic [DATA_W-1:0] rdata1,
   output logic [31:0]       ram_ctrl_to_hw,
   input  logic [31:0]       ram_ctrl_from_hw,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data_to_hw,
   input  logic [DATA_W-1:0] data_from_hw,
   output logic              busy,
   output logic              err
);

   arb_state_t        state_q, state_d;
   logic              we_q, we_d;
   logic              win_q, win_d;
   logic              ptr_q, ptr_d;      // port preferred on the next tie
   logic [DATA_W-1:0] rdcap_q, rdcap_d;
   logic [31:0]       ctrl_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdat_d;
   logic              done0_d, done1_d;
   logic [DATA_W-1:0] rdata0_d, rdata1_d;
   logic              busy_d;
   logic              grant;
   logic              ack;
   logic              unused_ctrl;

   assign ack         = ram_ctrl_from_hw[RAM_ACK];
   assign unused_ctrl = ^ram_ctrl_from_hw;

   rr_pick2 u_pick (
      .req0  (req0),
      .req1  (req1),
      .last  (~ptr_q),
      .fixed (FIXED_PRIO != 0),
      .grant (grant)
   );

`ifdef RAM_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_d;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYC == 0);
   assign err            = 1'b0;
`endif

   // Next-state and next-output logic for the handshake FSM
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      win_d    = win_q;
      ptr_d    = ptr_q;
      rdcap_d  = rdcap_q;
      ctrl_d   = ram_ctrl_to_hw;
      addr_d   = addr;
      wdat_d   = data_to_hw;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      rdata0_d = rdata0;
      rdata1_d = rdata1;
      case (state_q)
         ARB_IDLE: begin
            if (req0 || req1) begin
               win_d   = grant;
               we_d    = grant ? we1    : we0;
               addr_d  = grant ? addr1  : addr0;
               wdat_d  = grant ? wdata1 : wdata0;
               state_d = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            if (!ack) begin
               ctrl_d  = ctrl_pin(we_q);
               state_d = ARB_WAIT_ACK;
            end
         end
         ARB_WAIT_ACK: begin
            if (ack) begin
               if (!we_q) rdcap_d = data_from_hw;
               ctrl_d  = '0;
               state_d = ARB_RELEASE;
            end
         end
         ARB_RELEASE: begin
            if (!ack) begin
               if (win_q) begin
                  done1_d = 1'b1;
                  if (!we_q) rdata1_d = rdcap_q;
               end else begin
                  done0_d = 1'b1;
                  if (!we_q) rdata0_d = rdcap_q;
               end
               ptr_d   = ~win_q;
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
`ifdef RAM_ARB_TIMEOUT_EN
      err_d = err;
      cnt_d = (state_q == ARB_IDLE) ? '0 : cnt_q + 1'b1;
      // A normal completion in the same cycle takes precedence over the abort
      if (state_q != ARB_IDLE && state_d != ARB_IDLE &&
          cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
         ctrl_d = '0;
         err_d  = 1'b1;
         if (win_q) begin
            done1_d  = 1'b1;
            rdata1_d = '0;
         end else begin
            done0_d  = 1'b1;
            rdata0_d = '0;
         end
         ptr_d   = ~win_q;
         state_d = ARB_IDLE;
      end
`endif
      busy_d = (state_d != ARB_IDLE);
   end

   // State and registered outputs; async reset drops the pins at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ARB_IDLE;
         we_q           <= 1'b0;
         win_q          <= 1'b0;
         ptr_q          <= 1'b0;
         rdcap_q        <= '0;
         ram_ctrl_to_hw <= '0;
         addr           <= '0;
         data_to_hw     <= '0;
         done0          <= 1'b0;
         done1          <= 1'b0;
         rdata0         <= '0;
         rdata1         <= '0;
         busy           <= 1'b0;
      end else begin
         state_q        <= state_d;
         we_q           <= we_d;
         win_q          <= win_d;
         ptr_q          <= ptr_d;
         rdcap_q        <= rdcap_d;
         ram_ctrl_to_hw <= ctrl_d;
         addr           <= addr_d;
         data_to_hw     <= wdat_d;
         done0          <= done0_d;
         done1          <= done1_d;
         rdata0         <= rdata0_d;
         rdata1         <= rdata1_d;
         busy           <= busy_d;
      end
   end

`ifdef RAM_ARB_TIMEOUT_EN
   // Watchdog counter and sticky error flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         err   <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err   <= err_d;
      end
   end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: instance 0 is round-robin, instance 1 is
// fixed-priority with an 8-cycle watchdog limit. Each has its own RAM model.
module tb_ram_arbiter;
   import ram_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;

   logic        done0_v [2];
   logic        done1_v [2];
   logic        busy_v  [2];
   logic        err_v   [2];
   logic [31:0] rdata0_v[2];
   logic [31:0] rdata1_v[2];
   logic [31:0] ctl_to  [2];
   logic [31:0] ctl_from[2];
   logic [31:0] ram_addr[2];
   logic [31:0] d_to    [2];
   logic [31:0] d_from  [2];

   int n_cmp = 0;
   int n_bad = 0;

   ram_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT_CYC(1024)) u_rr (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0_v[0]), .rdata0(rdata0_v[0]),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1_v[0]), .rdata1(rdata1_v[0]),
      .ram_ctrl_to_hw(ctl_to[0]), .ram_ctrl_from_hw(ctl_from[0]), .addr(ram_addr[0]),
      .data_to_hw(d_to[0]), .data_from_hw(d_from[0]), .busy(busy_v[0]), .err(err_v[0]));

   ram_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT_CYC(8)) u_fix (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .done0(done0_v[1]), .rdata0(rdata0_v[1]),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .done1(done1_v[1]), .rdata1(rdata1_v[1]),
      .ram_ctrl_to_hw(ctl_to[1]), .ram_ctrl_from_hw(ctl_from[1]), .addr(ram_addr[1]),
      .data_to_hw(d_to[1]), .data_from_hw(d_from[1]), .busy(busy_v[1]), .err(err_v[1]));

   // RAM model controls
   int          ack_delay = 3;
   bit          ack_hold[2] = '{0, 0};
   bit          mute[2]     = '{0, 0};
   logic [31:0] ram_rdata   = 32'h0;
   int          mcnt[2];
   logic [31:0] wr_addr_log[2];
   logic [31:0] wr_data_log[2];

   // RAM model: ack after ack_delay cycles of a pin, drop ack after the pin falls
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (!rst) begin
            mcnt[g]     <= 0;
            ctl_from[g] <= '0;
            d_from[g]   <= '0;
         end else if (ack_hold[g]) begin
            ctl_from[g][RAM_ACK] <= 1'b1;
         end else if ((ctl_to[g][RAM_READ_PIN] || ctl_to[g][RAM_WRITE_PIN]) && !ctl_from[g][RAM_ACK]) begin
            if (!mute[g]) begin
               if (mcnt[g] + 1 >= ack_delay) begin
                  ctl_from[g][RAM_ACK] <= 1'b1;
                  mcnt[g] <= 0;
                  if (ctl_to[g][RAM_WRITE_PIN]) begin
                     wr_addr_log[g] <= ram_addr[g];
                     wr_data_log[g] <= d_to[g];
                  end else begin
                     d_from[g] <= ram_rdata;
                  end
               end else begin
                  mcnt[g] <= mcnt[g] + 1;
               end
            end
         end else if (!ctl_to[g][RAM_READ_PIN] && !ctl_to[g][RAM_WRITE_PIN]) begin
            ctl_from[g][RAM_ACK] <= 1'b0;
         end
      end
   end

   // Bus monitor counters
   int          both_hi[2], wr_cyc[2], rd_cyc[2], unstable[2], stale_iss[2];
   int          n_done0[2], n_done1[2];
   int          q_rr[$];
   int          q_fx[$];
   logic        pin_prev[2], ack_prev[2];
   logic [31:0] addr_prev[2], dto_prev[2];

   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         logic pin;
         pin = ctl_to[g][RAM_READ_PIN] | ctl_to[g][RAM_WRITE_PIN];
         if (ctl_to[g][RAM_READ_PIN] && ctl_to[g][RAM_WRITE_PIN]) both_hi[g]++;
         if (ctl_to[g][RAM_WRITE_PIN]) wr_cyc[g]++;
         if (ctl_to[g][RAM_READ_PIN])  rd_cyc[g]++;
         if (pin && pin_prev[g] && (ram_addr[g] != addr_prev[g] || d_to[g] != dto_prev[g])) unstable[g]++;
         if (pin && !pin_prev[g] && ack_prev[g]) stale_iss[g]++;
         if (done0_v[g]) begin
            n_done0[g]++;
            if (g == 0) q_rr.push_back(0); else q_fx.push_back(0);
         end
         if (done1_v[g]) begin
            n_done1[g]++;
            if (g == 0) q_rr.push_back(1); else q_fx.push_back(1);
         end
         pin_prev[g]  = pin;
         ack_prev[g]  = ctl_from[g][RAM_ACK];
         addr_prev[g] = ram_addr[g];
         dto_prev[g]  = d_to[g];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one transaction on port p and wait for done on instance g
   task automatic run_txn(input int g, input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int cyc, output logic ok);
      @(negedge clk);
      if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
      else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
      ok  = 1'b0;
      cyc = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         cyc++;
         if (p == 0 ? done0_v[g] : done1_v[g]) ok = 1'b1;
      end
      if (p == 0) req0 = 1'b0; else req1 = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (!busy_v[0] && !busy_v[1]) ok = 1'b1;
      end
      check(tag, ok, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int   cyc, b_wr, b_rd, b_both, b_uns, b_d0, b_d1, b_st, b0, b1;
      logic ok;

      // Reset state
      repeat (2) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check("rst_ctrl",  ctl_to[g],   '0);
         check("rst_addr",  ram_addr[g], '0);
         check("rst_dto",   d_to[g],     '0);
         check("rst_busy",  busy_v[g],   '0);
         check("rst_done",  {done0_v[g], done1_v[g]}, '0);
         check("rst_rdata", {rdata0_v[g], rdata1_v[g]}, '0);
         check("rst_err",   err_v[g],    '0);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 1: port 0 write, ack after 3 cycles
      ack_delay = 3;
      b_wr = wr_cyc[0]; b_rd = rd_cyc[0]; b_both = both_hi[0]; b_uns = unstable[0];
      b_d0 = n_done0[0]; b_d1 = n_done1[0];
      run_txn(0, 0, 1'b1, 32'h10, 32'hDEAD, cyc, ok);
      repeat (2) @(negedge clk);
      check("t1_done",     ok, 1'b1);
      check("t1_latency",  cyc, 8);
      check("t1_pulses",   n_done0[0] - b_d0, 1);
      check("t1_no_done1", n_done1[0] - b_d1, 0);
      check("t1_wr_cyc",   wr_cyc[0] - b_wr, 4);
      check("t1_rd_cyc",   rd_cyc[0] - b_rd, 0);
      check("t1_stable",   unstable[0] - b_uns, 0);
      check("t1_ram_addr", wr_addr_log[0], 32'h10);
      check("t1_ram_data", wr_data_log[0], 32'hDEAD);
      check("t1_rdata0",   rdata0_v[0], 32'h0);
      check("t1_idle",     busy_v[0], 1'b0);

      // 2: port 1 read returning 0x1234
      ram_rdata = 32'h1234;
      b_wr = wr_cyc[0]; b_rd = rd_cyc[0];
      run_txn(0, 1, 1'b0, 32'h20, 32'h0, cyc, ok);
      repeat (2) @(negedge clk);
      check("t2_done",   ok, 1'b1);
      check("t2_rdata1", rdata1_v[0], 32'h1234);
      check("t2_wr_cyc", wr_cyc[0] - b_wr, 0);
      check("t2_rd_cyc", rd_cyc[0] - b_rd, 4);
      check("t2_rdata0", rdata0_v[0], 32'h0);

      // 3: both ports continuously requesting
      b0 = q_rr.size(); b1 = q_fx.size();
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h30;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h40;
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (q_rr.size() >= b0 + 4 && q_fx.size() >= b1 + 4) ok = 1'b1;
      end
      req0 = 1'b0; req1 = 1'b0;
      check("t3_bounded", ok, 1'b1);
      if (ok) begin
         for (int i = 0; i < 4; i++) begin
            check("t3_rr_order",  q_rr[b0 + i], i % 2);
            check("t3_fix_order", q_fx[b1 + i], 1);
         end
      end
      wait_idle("t3_idle");

      // 4: stale ack at issue
      ack_hold[0] = 1'b1;
      repeat (2) @(negedge clk);
      b_wr = wr_cyc[0]; b_rd = rd_cyc[0]; b_st = stale_iss[0]; b_d0 = n_done0[0];
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h50; wdata0 = 32'hBEEF;
      repeat (4) @(negedge clk);
      check("t4_no_pin", (wr_cyc[0] - b_wr) + (rd_cyc[0] - b_rd), 0);
      check("t4_busy",   busy_v[0], 1'b1);
      ack_hold[0] = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (done0_v[0]) ok = 1'b1;
      end
      req0 = 1'b0;
      repeat (2) @(negedge clk);
      check("t4_done",    ok, 1'b1);
      check("t4_pulses",  n_done0[0] - b_d0, 1);
      check("t4_stale",   stale_iss[0] - b_st, 0);
      check("t4_wr_data", wr_data_log[0], 32'hBEEF);
      wait_idle("t4_idle");

      // 5: async reset during WAIT_ACK
      ack_delay = 40;
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h60;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (ctl_to[0][RAM_READ_PIN]) ok = 1'b1;
      end
      check("t5_pin_seen", ok, 1'b1);
      repeat (2) @(negedge clk);
      b_d1 = n_done1[0];
      #2 rst = 1'b0;
      #1;
      check("t5_pins_drop", ctl_to[0], '0);
      check("t5_busy_drop", busy_v[0], 1'b0);
      check("t5_no_done",   done1_v[0], 1'b0);
      req1 = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_no_done_rst", n_done1[0] - b_d1, 0);
      check("t5_rdata1_clr",  rdata1_v[0], 32'h0);
      rst = 1'b1;
      ack_delay = 2;
      ram_rdata = 32'hCAFE;
      run_txn(0, 0, 1'b0, 32'h70, 32'h0, cyc, ok);
      check("t5_done",    ok, 1'b1);
      check("t5_latency", cyc, 7);
      @(negedge clk);
      check("t5_rdata0",  rdata0_v[0], 32'hCAFE);
      check("t5_err",     err_v[0], 1'b0);
      check("t5_both_hi", both_hi[0] + both_hi[1], 0);
      wait_idle("t5_idle");

`ifdef RAM_ARB_TIMEOUT_EN
      // 6: watchdog on the 8-cycle instance, RAM never acks
      mute[1] = 1'b1;
      run_txn(1, 0, 1'b0, 32'h80, 32'h0, cyc, ok);
      check("t6_done",    ok, 1'b1);
      check("t6_latency", cyc, 9);
      check("t6_err",     err_v[1], 1'b1);
      check("t6_pins",    ctl_to[1], '0);
      check("t6_rdata0",  rdata0_v[1], 32'h0);
      repeat (5) @(negedge clk);
      check("t6_err_sticky", err_v[1], 1'b1);
      rst = 1'b0;
      @(negedge clk);
      check("t6_err_clr", err_v[1], 1'b0);
      rst = 1'b1;
      mute[1] = 1'b0;
      wait_idle("t6_idle");
`else
      check("err_tied0", {err_v[0], err_v[1]}, 2'b00);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
